// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Behavioural memory endpoint for the GPU data-memory controller. Holds a
// 2^ADDR_BITS x DATA_BITS array. Each request channel has its own small FSM,
// and all channels run independently. A read or write is answered with a
// one-cycle registered ready pulse LATENCY cycles after the request is
// accepted. A side-band preload port writes the array in every state,
// including while reset is low.
//
// Optional feature macro: MEM_RESPONDER_JITTER_EN
//   When defined, a free-running 8-bit LFSR adds 0-3 extra busy cycles to
//   each accepted request. When undefined, latency is exactly LATENCY.
//
// Ports
//   clk                in   clock, rising edge
//   reset              in   synchronous, active-low
//   mem_read_valid     in   [NUM_CHANNELS] read request per channel
//   mem_read_address   in   [NUM_CHANNELS][ADDR_BITS] read address
//   mem_read_ready     out  [NUM_CHANNELS] one-cycle read response pulse
//   mem_read_data      out  [NUM_CHANNELS][DATA_BITS] read data; holds after the pulse
//   mem_write_valid    in   [NUM_CHANNELS] write request per channel
//   mem_write_address  in   [NUM_CHANNELS][ADDR_BITS] write address
//   mem_write_data     in   [NUM_CHANNELS][DATA_BITS] write data
//   mem_write_ready    out  [NUM_CHANNELS] one-cycle write acknowledge pulse
//   load_enable        in   preload strobe
//   load_address       in   [ADDR_BITS] preload address
//   load_data          in   [DATA_BITS] preload data
//
// Per-channel states
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   S_IDLE    | waiting for a request; read wins over write
//   S_BUSY    | counting down the remaining latency
//   S_RESPOND | access edge: memory is read or written, ready is registered
//   S_RELEASE | ready pulse visible; waits for the requesting valid to drop
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2   // legal range 1-15
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   load_enable,
  input  logic [ADDR_BITS-1:0]                   load_address,
  input  logic [DATA_BITS-1:0]                   load_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Wide enough for LATENCY-1 plus up to 3 jitter cycles (max 17).
  localparam int              CNT_W    = 5;
  localparam int              DEPTH    = 1 << ADDR_BITS;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [NUM_CHANNELS-1:0][1:0]           state_q, state_d;
  logic [NUM_CHANNELS-1:0]                op_q, op_d;
  logic [NUM_CHANNELS-1:0][CNT_W-1:0]     cnt_q, cnt_d, cnt_load;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata_q, wdata_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic [NUM_CHANNELS-1:0]                rready_q, rready_d;
  logic [NUM_CHANNELS-1:0]                wready_q, wready_d;
  logic [NUM_CHANNELS-1:0][1:0]           extra;

`ifdef MEM_RESPONDER_JITTER_EN
  // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting toward the MSB.
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_jit
    assign extra[c] = {lfsr_q[(2*c+1)%8], lfsr_q[(2*c)%8]};
  end
`else
  assign extra = '0;
`endif

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      cnt_load[c] = LAT_LOAD + CNT_W'(extra[c]);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rready_d = '0;
    wready_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        S_IDLE: begin
          if (mem_read_valid[c]) begin
            op_d[c]    = OP_READ;
            addr_d[c]  = mem_read_address[c];
            cnt_d[c]   = cnt_load[c];
            // A zero load means the access happens on the very next edge.
            state_d[c] = (cnt_load[c] == '0) ? S_RESPOND : S_BUSY;
          end else if (mem_write_valid[c]) begin
            op_d[c]    = OP_WRITE;
            addr_d[c]  = mem_write_address[c];
            wdata_d[c] = mem_write_data[c];
            cnt_d[c]   = cnt_load[c];
            state_d[c] = (cnt_load[c] == '0) ? S_RESPOND : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
          if (cnt_q[c] == CNT_W'(1)) begin
            state_d[c] = S_RESPOND;
          end
        end
        S_RESPOND: begin
          // Memory is read before this edge's writes land, so a same-cycle
          // read/write collision returns the old value.
          if (op_q[c] == OP_READ) begin
            rready_d[c] = 1'b1;
            rdata_d[c]  = mem_q[addr_q[c]];
          end else begin
            wready_d[c] = 1'b1;
          end
          state_d[c] = S_RELEASE;
        end
        default: begin
          if (op_q[c] == OP_READ ? !mem_read_valid[c] : !mem_write_valid[c]) begin
            state_d[c] = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rready_q <= '0;
      wready_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rready_q <= rready_d;
      wready_q <= wready_d;
    end
  end

  // Array is never reset. Preload goes first so any channel write to the same
  // address overrides it; ascending loop order lets the highest channel win.
  always_ff @(posedge clk) begin
    if (load_enable) begin
      mem_q[load_address] <= load_data;
    end
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (state_q[c] == S_RESPOND && op_q[c] == OP_WRITE) begin
          mem_q[addr_q[c]] <= wdata_q[c];
        end
      end
    end
  end

  assign mem_read_ready  = rready_q;
  assign mem_write_ready = wready_q;
  assign mem_read_data   = rdata_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Behavioural-synthesizable memory responder for the data-memory side of the GPU. It answers the multi-channel read/write valid/ready protocol that the GPU's data memory controller issues. It holds a 2^ADDR_BITS x DATA_BITS array and serves every channel independently with a programmable response latency. It is used as the memory endpoint in system benches and FPGA bring-up, and includes a side-band preload port for kernel data.

## Interface
Parameters:
- ADDR_BITS, 8, address width; array depth 2^ADDR_BITS
- DATA_BITS, 8, data word width
- NUM_CHANNELS, 4, independent request channels
- LATENCY, 2, cycles from request acceptance to ready pulse; legal range 1-15

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- mem_read_valid  in  [NUM_CHANNELS]  per-channel read request
- mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address
- mem_read_ready  out  [NUM_CHANNELS]  one-cycle read-response pulse
- mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data, valid while ready=1
- mem_write_valid  in  [NUM_CHANNELS]  per-channel write request
- mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address
- mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data
- mem_write_ready  out  [NUM_CHANNELS]  one-cycle write-acknowledge pulse
- load_enable  in  1  preload strobe
- load_address  in  ADDR_BITS  preload address
- load_data  in  DATA_BITS  preload data

## Operation
- Each channel has its own FSM: IDLE -> BUSY -> RESPOND -> RELEASE -> IDLE.
- IDLE: if read_valid=1, latch the address, set op=READ, load the counter with LATENCY-1 and go to BUSY. Else if write_valid=1, latch address and data, set op=WRITE, and go to BUSY. Read has priority when both are high; the write is accepted after the read completes.
- BUSY: decrement the counter. Go to RESPOND when it reaches 0, or immediately if LATENCY=1.
- RESPOND, READ: read_ready=1 and read_data=array[latched addr], sampled at this edge.
- RESPOND, WRITE: array[latched addr] <= latched data at this edge, and write_ready=1.
- RELEASE: ready=0. Stay until the requesting valid is 0, then go to IDLE. A new request is never accepted in the same cycle that valid is seen low.
- Write collisions in one RESPOND cycle to the same address: the highest-numbered channel wins. A channel write also beats a preload to the same address in the same cycle.
- Read/write same address, same cycle: the read returns the pre-write (old) value.
- Preload: when load_enable=1, array[load_address] <= load_data. It is honoured in every state, including while reset=0.
- Reset (reset=0):
  - All FSMs go to IDLE and counters are cleared.
  - All ready outputs go to 0 and all read_data outputs go to 0.
  - Array contents are retained.
  - An in-flight request is dropped with no response. The controller is reset by the same signal.
- Addresses wrap naturally within ADDR_BITS; there are no out-of-range checks.

## Timing
- A request seen in IDLE at edge T produces ready high during cycle T+LATENCY, plus any jitter (see Configuration).
- Ready is exactly one cycle wide and is a registered output.
- read_data holds its last value after ready falls; it is 0 after reset.
- Back-to-back requests on one channel cost a minimum of LATENCY+2 cycles, provided valid drops the cycle after ready.
- Channels never stall one another.
- The preload write is visible to a read whose RESPOND edge is later than the load edge.

## Configuration
- MEM_RESPONDER_JITTER_EN defined:
  - A free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every cycle.
  - On acceptance, the channel adds LFSR[1:0] (0-3) extra BUSY cycles, so latency is LATENCY to LATENCY+3.
  - Channel c uses bits {LFSR[(2c+1)%8], LFSR[(2c)%8]}.
- Undefined: latency is exactly LATENCY, with no LFSR logic.

## Test plan
- Preload addr 8'h10=8'h2A. Channel 0 read addr 8'h10 with LATENCY=2, valid at edge T -> read_ready[0]=1 only in cycle T+2 with data 8'h2A, then RELEASE until valid drops.
- Channel 1 write 8'h33->8'h05, then channel 2 read 8'h05 -> write_ready[1] pulses once, and the read returns 8'h33.
- Channels 0 and 3 both write 8'h07 in the same RESPOND cycle, with data 8'h11 and 8'h22 -> subsequent read returns 8'h22.
- Channel 0 read and write valid together (read addr 8'h01, write 8'h01<-8'h99), memory 8'h01=8'h00 -> read_ready first with 8'h00, then write_ready, then a read returns 8'h99.
- Reset low while channel 2 is in BUSY -> next cycle all ready=0, read_data=0, FSM in IDLE; preloaded contents are unchanged on a later read.
- With MEM_RESPONDER_JITTER_EN over 200 random requests -> every latency is within [LATENCY, LATENCY+3], and all four extra-latency values occur.
